// File: rtl/cpu_pkg.sv
// Shared CPU constants and register-index types used by writeback, the register file and decode.
package cpu_pkg;
  localparam int DataWidth = 24;
  localparam int NumRegs   = 24;
  localparam int AddrWidth = 5;
  localparam int MaxLoads  = 4;
  localparam int PendWidth = $clog2(MaxLoads + 1);

  typedef logic [AddrWidth-1:0] reg_idx_t;
  typedef logic [DataWidth-1:0] reg_data_t;
  typedef logic [PendWidth-1:0] pend_cnt_t;

  function automatic logic idx_in_range(input reg_idx_t idx);
    return int'(idx) < NumRegs;
  endfunction

  // Out-of-range indices read as not-busy instead of indexing past the vector.
  function automatic logic busy_at(input logic [NumRegs-1:0] busy, input reg_idx_t idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (int'(idx) == i) hit = busy[i];
    end
    return hit;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector: one set port (issue) and one clear port (commit), registered output.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               SetEn,
  input  reg_idx_t           SetIdx,
  input  logic               ClrEn,
  input  reg_idx_t           ClrIdx,
  output logic [NumRegs-1:0] Busy
);
  logic [NumRegs-1:0] set_mask;
  logic [NumRegs-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (SetEn && int'(SetIdx) == i) set_mask[i] = 1'b1;
      if (ClrEn && int'(ClrIdx) == i) clr_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) Busy <= '0;
    else         Busy <= (Busy & ~clr_mask) | set_mask;
  end
endmodule

// File: rtl/writeback_scoreboard.sv
// Writeback stage: arbitrates ALU and load results into one registered register-file write port,
// tracking busy destinations and outstanding loads so decode can stall.
module writeback_scoreboard
  import cpu_pkg::*;
(
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 IssueValid,
  input  logic [AddrWidth-1:0] IssueRD,
  input  logic                 IssueIsLoad,
  output logic                 IssueReady,
  input  logic                 AluValid,
  input  logic [AddrWidth-1:0] AluRD,
  input  logic [DataWidth-1:0] AluResult,
  input  logic                 MemValid,
  input  logic [AddrWidth-1:0] MemRD,
  input  logic [DataWidth-1:0] MemData,
  output logic                 MemReady,
  output logic [AddrWidth-1:0] RD,
  output logic [DataWidth-1:0] WriteData,
  output logic                 RegWrite,
  output logic [NumRegs-1:0]   Busy,
  output logic                 Error
);
  // Handshakes: a transfer happens in a cycle where valid && ready are both high at the rising
  // edge; ready never depends on the same channel's valid, and a stalled source holds its payload.
  pend_cnt_t pending;
  logic      issue_in_range, loads_full, issue_fire, mem_fire;
  logic      res_take, res_ok, err_set, pend_inc, pend_dec;
  reg_idx_t  res_rd;
  reg_data_t res_data;

  always_comb begin
    issue_in_range = idx_in_range(IssueRD);
    loads_full     = (pending == pend_cnt_t'(MaxLoads));
    IssueReady     = issue_in_range ? (!busy_at(Busy, IssueRD) && !(IssueIsLoad && loads_full))
                                    : 1'b1;
    MemReady       = !AluValid;
    issue_fire     = IssueValid && IssueReady;
    mem_fire       = MemValid && MemReady;

    res_take = AluValid || mem_fire;
    res_rd   = AluValid ? AluRD : MemRD;
    res_data = AluValid ? AluResult : MemData;
    // A load result with no load outstanding is a protocol error even if its register is busy.
    res_ok   = res_take && idx_in_range(res_rd) && busy_at(Busy, res_rd)
               && (AluValid || pending != '0);

    err_set  = (issue_fire && !issue_in_range) || (res_take && !res_ok);
    pend_inc = issue_fire && issue_in_range && IssueIsLoad;
    pend_dec = mem_fire && pending != '0;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pending <= '0;
    end else if (pend_inc && !pend_dec) begin
      pending <= pending + pend_cnt_t'(1);
    end else if (pend_dec && !pend_inc) begin
      pending <= pending - pend_cnt_t'(1);
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      RD        <= '0;
      WriteData <= '0;
      RegWrite  <= 1'b0;
    end else begin
      RegWrite <= res_ok;
      if (res_ok) begin
        RD        <= res_rd;
        WriteData <= res_data;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)      Error <= 1'b0;
    else if (err_set) Error <= 1'b1;
  end

  reg_scoreboard u_reg_scoreboard (
    .Clock  (Clock),
    .ResetN (ResetN),
    .SetEn  (issue_fire && issue_in_range),
    .SetIdx (IssueRD),
    .ClrEn  (res_ok),
    .ClrIdx (res_rd),
    .Busy   (Busy)
  );
endmodule
